// File: rtl/arc4_pkg.sv
// arc4_pkg: shared ARC4 types and constants.
//   byte_t            - 8-bit data/address byte
//   ARC4_MEM_DEPTH    - depth of S, plaintext and ciphertext memories
//   arc4_enc_state_e  - encrypt engine state encoding (also for decrypt paths)
package arc4_pkg;

   typedef logic [7:0] byte_t;

   localparam int unsigned ARC4_MEM_DEPTH = 256;

   typedef enum logic [3:0] {
      IDLE,
      RD_LEN,
      WR_LEN,
      RD_I,
      RD_J,
      WR_I,
      WR_J,
      RD_PAD,
      WR_CT
   } arc4_enc_state_e;

endpackage

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 PRGA encryption engine. Reads a length-prefixed plaintext
// memory, runs the keystream over an already key-scheduled S memory and writes
// the ciphertext memory. All memories are external and synchronous-read.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en / rdy            start request (sampled while rdy=1) / idle indicator
//   s_addr, s_rddata,   S memory port (read/write)
//   s_wrdata, s_wren
//   pt_addr, pt_rddata  plaintext memory port (read-only)
//   ct_addr, ct_wrdata, ciphertext memory port (write-only)
//   ct_wren
//
// Configuration macro ARC4_ENC_PREFIX_EN:
//   defined   - ct[0]=L, payload at ct[1..L]
//   undefined - no length write, payload at ct[0..L-1]; timing unchanged
module arc4_encrypt
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic [7:0] ct_addr,
   output logic [7:0] ct_wrdata,
   output logic       ct_wren
);

   arc4_enc_state_e state_q, state_d;
   byte_t i_q, i_d;
   byte_t j_q, j_d;
   byte_t k_q, k_d;
   byte_t len_q, len_d;
   byte_t si_q, si_d;
   byte_t sj_q, sj_d;
   byte_t ptk_q, ptk_d;

   // Next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      len_d   = len_q;
      si_d    = si_q;
      sj_d    = sj_q;
      ptk_d   = ptk_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = RD_LEN;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         RD_LEN: state_d = WR_LEN;
         WR_LEN: begin
            len_d = pt_rddata;
            if (pt_rddata == '0) begin
               state_d = IDLE;
            end else begin
               k_d     = 8'd1;
               state_d = RD_I;
            end
         end
         RD_I: begin
            i_d     = i_q + 8'd1;
            state_d = RD_J;
         end
         RD_J: begin
            si_d    = s_rddata;
            ptk_d   = pt_rddata;
            j_d     = j_q + s_rddata;
            state_d = WR_I;
         end
         WR_I: begin
            sj_d    = s_rddata;
            state_d = WR_J;
         end
         WR_J:   state_d = RD_PAD;
         RD_PAD: state_d = WR_CT;
         WR_CT: begin
            if (k_q == len_q) begin
               state_d = IDLE;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = RD_I;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory-port outputs decode straight from state so each access lands in
   // the cycle its state names; everything is zero outside an access.
   always_comb begin
      rdy       = (state_q == IDLE);
      s_addr    = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      pt_addr   = '0;
      ct_addr   = '0;
      ct_wrdata = '0;
      ct_wren   = 1'b0;
      case (state_q)
         WR_LEN: begin
`ifdef ARC4_ENC_PREFIX_EN
            ct_wrdata = pt_rddata;
            ct_wren   = 1'b1;
`endif
         end
         RD_I: begin
            s_addr  = i_q + 8'd1;
            pt_addr = k_q;
         end
         // j is updated with the S[i] just returned, so address the new j now
         RD_J: s_addr = j_q + s_rddata;
         WR_I: begin
            s_addr   = i_q;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
         end
         // When i=j this second write wins, leaving S[i]=si as required
         WR_J: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
         end
         RD_PAD: s_addr = si_q + sj_q;
         WR_CT: begin
`ifdef ARC4_ENC_PREFIX_EN
            ct_addr = k_q;
`else
            ct_addr = k_q - 8'd1;
`endif
            ct_wrdata = s_rddata ^ ptk_q;
            ct_wren   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         len_q   <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         ptk_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         ptk_q   <= ptk_d;
      end
   end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: self-checking bench for arc4_encrypt with synchronous-read
// memory models and a behavioural ARC4 reference model.
module tb_arc4_encrypt;
   import arc4_pkg::*;

`ifdef ARC4_ENC_PREFIX_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       rdy;
   logic [7:0] s_addr, s_rddata, s_wrdata;
   logic       s_wren;
   logic [7:0] pt_addr, pt_rddata;
   logic [7:0] ct_addr, ct_wrdata;
   logic       ct_wren;

   logic [7:0] s_mem [256];
   logic [7:0] pt_mem [256];
   logic [7:0] ct_mem [256];
   logic [7:0] s_stage [256];
   logic       load_req = 1'b0;
   int         ct_wr_cnt = 0;
   int         s_wr_cnt = 0;

   logic [7:0] ms [256];
   logic [7:0] exp_ct [256];
   int         exp_ct_wr;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] plain [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
   logic [7:0] known [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
   logic [7:0] saved [9];

   arc4_encrypt dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rdy       (rdy),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ct_addr   (ct_addr),
      .ct_wrdata (ct_wrdata),
      .ct_wren   (ct_wren)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories; a load request replaces S and clears ct
   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (load_req) begin
         for (int a = 0; a < 256; a++) begin
            s_mem[a]  <= s_stage[a];
            ct_mem[a] <= 8'hA5;
         end
         ct_wr_cnt <= 0;
         s_wr_cnt  <= 0;
      end else begin
         if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt      <= s_wr_cnt + 1;
         end
         if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            ct_wr_cnt       <= ct_wr_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) check("one_wren", {30'd0, s_wren, ct_wren} != 32'd3, 32'd1);
   end

   task automatic stage_identity();
      for (int a = 0; a < 256; a++) s_stage[a] = 8'(a);
   endtask

   task automatic stage_ksa(input logic [23:0] key);
      int j;
      logic [7:0] t, kb;
      stage_identity();
      j = 0;
      for (int i = 0; i < 256; i++) begin
         kb = (i % 3 == 0) ? key[23:16] : (i % 3 == 1) ? key[15:8] : key[7:0];
         j = (j + int'(s_stage[i]) + int'(kb)) % 256;
         t = s_stage[i]; s_stage[i] = s_stage[j]; s_stage[j] = t;
      end
   endtask

   task automatic stage_random_perm();
      int r;
      logic [7:0] t;
      stage_identity();
      for (int i = 255; i > 0; i--) begin
         r = int'($urandom_range(0, i));
         t = s_stage[i]; s_stage[i] = s_stage[r]; s_stage[r] = t;
      end
   endtask

   task automatic pt_random(input int l);
      pt_mem[0] = 8'(l);
      for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom);
   endtask

   // Plain ARC4 PRGA over a copy of the staged S
   task automatic model_run();
      int l, i, j;
      logic [7:0] t, pad;
      for (int a = 0; a < 256; a++) begin
         ms[a] = s_stage[a];
         exp_ct[a] = 8'hA5;
      end
      l = int'(pt_mem[0]);
      i = 0; j = 0;
      if (OFF == 1) exp_ct[0] = pt_mem[0];
      for (int k = 1; k <= l; k++) begin
         i = (i + 1) % 256;
         j = (j + int'(ms[i])) % 256;
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
         pad = ms[(int'(ms[i]) + int'(ms[j])) % 256];
         exp_ct[k - 1 + OFF] = pad ^ pt_mem[k];
      end
      exp_ct_wr = l + OFF;
   endtask

   task automatic do_run(input string tag, input bit noisy_en);
      int l, cyc, total;
      load_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_req = 1'b0;
      model_run();
      l = int'(pt_mem[0]);
      total = 2 + 6 * l;
      check({tag, "_rdy_pre"}, {31'd0, rdy}, 32'd1);
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      cyc = 0;
      while (rdy !== 1'b1 && cyc < 2000) begin
         cyc++;
         en = (noisy_en && cyc >= 2 && cyc < total) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
      end
      en = 1'b0;
      check({tag, "_cycles"}, cyc, total);
      check({tag, "_ct_writes"}, ct_wr_cnt, exp_ct_wr);
      check({tag, "_s_writes"}, s_wr_cnt, 2 * l);
      for (int a = 0; a < 256; a++) begin
         check({tag, "_ct_", $sformatf("%0d", a)}, {24'd0, ct_mem[a]}, {24'd0, exp_ct[a]});
         check({tag, "_s_", $sformatf("%0d", a)}, {24'd0, s_mem[a]}, {24'd0, ms[a]});
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
      stage_identity();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", {31'd0, rdy}, 32'd1);
      check("rst_s_wren", {31'd0, s_wren}, 32'd0);
      check("rst_ct_wren", {31'd0, ct_wren}, 32'd0);
      check("rst_s_addr", {24'd0, s_addr}, 32'd0);
      check("rst_pt_addr", {24'd0, pt_addr}, 32'd0);
      check("rst_ct_addr", {24'd0, ct_addr}, 32'd0);
      check("rst_s_wrdata", {24'd0, s_wrdata}, 32'd0);
      check("rst_ct_wrdata", {24'd0, ct_wrdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Identity S, one byte: pad is S[2]=2
      stage_identity();
      pt_random(1);
      pt_mem[1] = 8'h41;
      do_run("ident1", 1'b0);
      check("ident1_known", {24'd0, ct_mem[OFF]}, 32'h43);

      // Key "Key", "Plaintext"
      stage_ksa(24'h4B6579);
      pt_random(9);
      for (int b = 0; b < 9; b++) pt_mem[1 + b] = plain[b];
      do_run("plain", 1'b0);
      for (int b = 0; b < 9; b++) begin
         check($sformatf("plain_known_%0d", b), {24'd0, ct_mem[b + OFF]}, {24'd0, known[b]});
         saved[b] = ct_mem[b + OFF];
      end

      // Round trip: encrypting the ciphertext with the same key restores pt
      stage_ksa(24'h4B6579);
      for (int b = 0; b < 9; b++) pt_mem[1 + b] = saved[b];
      do_run("round", 1'b0);
      for (int b = 0; b < 9; b++)
         check($sformatf("round_pt_%0d", b), {24'd0, ct_mem[b + OFF]}, {24'd0, plain[b]});

      // Zero length
      stage_random_perm();
      pt_random(0);
      do_run("len0", 1'b0);

      // Two bytes on identity S: pads 2 and 5
      stage_identity();
      pt_random(2);
      pt_mem[1] = 8'h41;
      pt_mem[2] = 8'h42;
      do_run("ident2", 1'b0);
      check("ident2_b0", {24'd0, ct_mem[OFF]}, 32'h43);
      check("ident2_b1", {24'd0, ct_mem[OFF + 1]}, 32'h47);

      // Reset in the middle of the "Plaintext" run
      stage_ksa(24'h4B6579);
      pt_random(9);
      for (int b = 0; b < 9; b++) pt_mem[1 + b] = plain[b];
      load_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_req = 1'b0;
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_rdy", {31'd0, rdy}, 32'd1);
      check("midrst_s_wren", {31'd0, s_wren}, 32'd0);
      check("midrst_ct_wren", {31'd0, ct_wren}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      do_run("after_rst", 1'b0);
      for (int b = 0; b < 9; b++)
         check($sformatf("after_rst_known_%0d", b), {24'd0, ct_mem[b + OFF]}, {24'd0, known[b]});

      // Random permutations and lengths, with en toggling while busy
      for (int r = 0; r < 5; r++) begin
         stage_random_perm();
         pt_random(int'($urandom_range(1, 40)));
         do_run($sformatf("rand%0d", r), 1'b1);
      end

      // Maximum length
      stage_random_perm();
      pt_random(255);
      do_run("len255", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
